// File: rtl/unified_memory.sv
// Word-addressed unified instruction/data memory with fixed, parameterised response latency.
// Optional misaligned-access detection is enabled by defining MEM_ALIGN_CHECK_EN.
module unified_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            enter_resp;

  logic            cap_we;
  logic [AW+1:0]   cap_addr;
  logic [31:0]     cap_wdata;

  logic            acc_we;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [AW-1:0]   idx;
  logic            misaligned;
  logic            err_q;

  logic [31:0]     mem [DEPTH_WORDS] = '{default: '0};

  // Address bits above the array size alias by design.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

  // With LATENCY=1 the array is accessed on the accepting edge, before capture registers load.
  assign acc_we    = (state == IDLE) ? req_we              : cap_we;
  assign acc_addr  = (state == IDLE) ? req_addr[AW+1:0]    : cap_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata           : cap_wdata;
  assign idx       = acc_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |acc_addr[1:0];
  assign resp_err   = err_q;
`else
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
`endif

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_next = RESP;
          cnt_next   = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr[AW+1:0];
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        if (misaligned)  resp_rdata <= '0;
        else if (acc_we) resp_rdata <= acc_wdata;
        else             resp_rdata <= mem[idx];
        err_q <= misaligned;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !misaligned) begin
      mem[idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_unified_memory.sv
// Self-checking bench for unified_memory (LATENCY=2, DEPTH_WORDS=256): vector table plus
// hand-written reset, back-to-back and alignment sequences.
module tb_unified_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  unified_memory #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block idle again.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int unsigned n = 0;
    rdata = '0;
    err   = 1'b0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    // scramble request inputs during WAIT: the captured copy must be used
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_addr  = addr ^ 32'h0000_0004;
    req_wdata = ~wdata;
    chk("wait_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("wait_not_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    req_we = 1'b0;
    chk("resp_pulse_end", {31'b0, resp_valid}, 32'd0);
    chk("ready_again", {31'b0, req_ready}, 32'd1);
    chk("rdata_hold", resp_rdata, rdata);
  endtask

  logic [31:0] rd;
  logic        er;
  int          accepts;
  int          resps;
  logic        prev_rv;
  logic [31:0] b2b_exp[2];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0014, 32'h0,         32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0404, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_03FC, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hAAAA_5555, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

    // reset held three cycles, request inputs toggling meanwhile
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h10 + 32'(i);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_rst_err", {31'b0, resp_err}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].err});
    end

    // scrambled we/addr during WAIT of the 0x10 load must not have written 0x14
    do_req(1'b0, 32'h14, 32'h0, rd, er);
    chk("hold_no_stray_write", rd, 32'd0);

    // back-to-back: req_valid held 6 cycles, address incrementing every cycle
    accepts = 0; resps = 0; prev_rv = 1'b0;
    b2b_exp[0] = 32'h0000_00B0;
    b2b_exp[1] = 32'h0000_00B3;
    for (int i = 0; i < 7; i++) begin
      if (resp_valid) begin
        chk("b2b_single_cycle", {31'b0, prev_rv}, 32'd0);
        if (resps < 2) chk($sformatf("b2b_resp%0d", resps), resp_rdata, b2b_exp[resps]);
        resps++;
      end
      prev_rv = resp_valid;
      if (i < 6) begin
        if (req_ready) accepts++;
        req_valid = 1'b1; req_we = 1'b1;
        req_addr  = 32'h80 + 32'(4 * i);
        req_wdata = 32'hB0 + 32'(i);
      end else begin
        req_valid = 1'b0; req_we = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(accepts), 32'd2);
    chk("b2b_resps", 32'(resps), 32'd2);
    do_req(1'b0, 32'h80, 32'h0, rd, er); chk("b2b_word80", rd, 32'hB0);
    do_req(1'b0, 32'h84, 32'h0, rd, er); chk("b2b_word84", rd, 32'h0);
    do_req(1'b0, 32'h88, 32'h0, rd, er); chk("b2b_word88", rd, 32'h0);
    do_req(1'b0, 32'h8C, 32'h0, rd, er); chk("b2b_word8C", rd, 32'hB3);

    // reset coinciding with the RESP-entry edge of a store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_ready_low", {31'b0, req_ready}, 32'd0);
    chk("rstmid_rdata", resp_rdata, 32'd0);
    // simultaneous rst and req_valid: not accepted
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstreq_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rstreq_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rstreq_no_resp2", {31'b0, resp_valid}, 32'd0);
    do_req(1'b0, 32'h20, 32'h0, rd, er);
    chk("rstmid_word20", rd, 32'h0);

    // misaligned store
    do_req(1'b1, 32'h22, 32'h5A5A_5A5A, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_rdata", rd, 32'h0);
    chk("align_err", {31'b0, er}, 32'd1);
    do_req(1'b0, 32'h20, 32'h0, rd, er);
    chk("align_word20", rd, 32'h0);
    chk("align_err_clear", {31'b0, er}, 32'd0);
`else
    chk("align_rdata", rd, 32'h5A5A_5A5A);
    chk("align_err", {31'b0, er}, 32'd0);
    do_req(1'b0, 32'h20, 32'h0, rd, er);
    chk("align_word20", rd, 32'h5A5A_5A5A);
    chk("align_err_clear", {31'b0, er}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
